// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: vsync frame ticks, round FSM, scores and ball-engine controls.
// Build option: define PONG_WIN_BY_TWO_EN to require a two-point lead to win (deuce play).
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter bit          VSYNC_POL    = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [2:0]         state,
    output logic               ball_reset,
    output logic               ball_run,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_FRAMES);
    localparam logic [SCORE_W:0]   WIN_TGT   = (SCORE_W+1)'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e             state_q;
    state_e             next_state;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               vs_q;
    logic               vs_qq;
    logic               start_q;
    logic               frame_tick;
    logic               clear_scores;
    logic [SCORE_W-1:0] score1_d;
    logic [SCORE_W-1:0] score2_d;
    logic               serve_dir_d;
    logic               winner_d;
    logic               ball_reset_d;
    logic               ball_run_d;
    logic               game_over_d;

    // Saturating score increment.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_SAT) ? s : s + SCORE_W'(1);
    endfunction

    // True when player a has won against b; saturation always ends the match.
    function automatic logic wins(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic lead;
`ifdef PONG_WIN_BY_TWO_EN
        lead = ({1'b0, a} >= ({1'b0, b} + (SCORE_W+1)'(2)));
`else
        lead = (a > b);
`endif
        return ((({1'b0, a} >= WIN_TGT) && lead) || (a == SCORE_SAT));
    endfunction

    assign frame_tick = (vs_q == VSYNC_POL) && (vs_qq != VSYNC_POL);
    assign state      = state_q;

    // Next-state, counter, score and output decode.
    always_comb begin
        next_state   = state_q;
        cnt_d        = cnt_q;
        score1_d     = score1;
        score2_d     = score2;
        serve_dir_d  = serve_dir;
        winner_d     = winner;
        clear_scores = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    next_state   = ST_SERVE;
                    clear_scores = 1'b1;
                end
            end
            ST_SERVE: begin
                if (cnt_q == SERVE_CNT) begin
                    next_state = ST_PLAY;
                end else if (frame_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    next_state = ST_SERVE;
                end else if (miss_left) begin
                    score2_d    = sat_inc(score2);
                    serve_dir_d = 1'b0;
                    next_state  = ST_POINT;
                end else if (miss_right) begin
                    score1_d    = sat_inc(score1);
                    serve_dir_d = 1'b1;
                    next_state  = ST_POINT;
                end
            end
            ST_POINT: begin
                if (cnt_q == POINT_CNT) begin
                    if (wins(score1, score2) || wins(score2, score1)) begin
                        next_state = ST_OVER;
                        winner_d   = (score2 > score1);
                    end else begin
                        next_state = ST_SERVE;
                    end
                end else if (frame_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OVER: begin
                if (start && !start_q) begin
                    next_state   = ST_SERVE;
                    clear_scores = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase

        if (clear_scores) begin
            score1_d = '0;
            score2_d = '0;
        end

        // Timed states always start counting from zero.
        if ((next_state != state_q) && ((next_state == ST_SERVE) || (next_state == ST_POINT))) begin
            cnt_d = '0;
        end

        ball_reset_d = (next_state == ST_SERVE) && (state_q != ST_SERVE);
        ball_run_d   = (next_state == ST_PLAY);
        game_over_d  = (next_state == ST_OVER);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vs_q       <= ~VSYNC_POL;
            vs_qq      <= ~VSYNC_POL;
            start_q    <= 1'b0;
            score1     <= '0;
            score2     <= '0;
            serve_dir  <= 1'b1;
            winner     <= 1'b0;
            ball_reset <= 1'b0;
            ball_run   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= next_state;
            cnt_q      <= cnt_d;
            vs_q       <= vsync;
            vs_qq      <= vs_q;
            start_q    <= start;
            score1     <= score1_d;
            score2     <= score2_d;
            serve_dir  <= serve_dir_d;
            winner     <= winner_d;
            ball_reset <= ball_reset_d;
            ball_run   <= ball_run_d;
            game_over  <= game_over_d;
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: vector table, directed match sequences,
// and randomized stimulus checked every cycle against a behavioural match model.
module tb_pong_match_ctrl;

    localparam int unsigned SW   = 4;
    localparam int          WIN  = 11;
    localparam int          SF   = 60;
    localparam int          PF   = 90;
    localparam int          SMAX = 15;
    localparam bit          POL  = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          start;
    logic          miss_left;
    logic          miss_right;
    logic [2:0]    state;
    logic          ball_reset;
    logic          ball_run;
    logic          serve_dir;
    logic [SW-1:0] score1;
    logic [SW-1:0] score2;
    logic          game_over;
    logic          winner;

    pong_match_ctrl #(
        .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .VSYNC_POL(POL)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .miss_left(miss_left), .miss_right(miss_right), .state(state),
        .ball_reset(ball_reset), .ball_run(ball_run), .serve_dir(serve_dir),
        .score1(score1), .score2(score2), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vs_phase = 0;

    // Behavioural match model: phase 0..4 = idle, serve, play, point, over.
    int m_phase, m_frames, m_s1, m_s2;
    bit m_dir, m_win, m_pulse, m_start_prev, m_vs1, m_vs2;

    function automatic bit m_wins(input int a, input int b);
        if (a == SMAX) return 1'b1;
`ifdef PONG_WIN_BY_TWO_EN
        return (a >= WIN) && (a - b >= 2);
`else
        return (a >= WIN);
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_s1 = 0; m_s2 = 0;
        m_dir = 1'b1; m_win = 1'b0; m_pulse = 1'b0; m_start_prev = 1'b0;
        m_vs1 = ~POL; m_vs2 = ~POL;
    endtask

    task automatic new_serve(input bit clear);
        m_phase = 1; m_frames = 0; m_pulse = 1'b1;
        if (clear) begin m_s1 = 0; m_s2 = 0; end
    endtask

    task automatic model_step(input bit vs, input bit st, input bit ml, input bit mr);
        bit tick, rise;
        tick = (m_vs1 == POL) && (m_vs2 != POL);
        m_vs2 = m_vs1; m_vs1 = vs;
        rise = st && !m_start_prev;
        m_start_prev = st;
        m_pulse = 1'b0;
        case (m_phase)
            0: if (st) new_serve(1'b1);
            1: if (m_frames == SF) m_phase = 2; else if (tick) m_frames++;
            2: begin
                if (ml && mr) new_serve(1'b0);
                else if (ml) begin
                    m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX; m_dir = 1'b0; m_phase = 3; m_frames = 0;
                end else if (mr) begin
                    m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX; m_dir = 1'b1; m_phase = 3; m_frames = 0;
                end
            end
            3: begin
                if (m_frames == PF) begin
                    if (m_wins(m_s1, m_s2) || m_wins(m_s2, m_s1)) begin
                        m_phase = 4; m_win = (m_s2 > m_s1);
                    end else new_serve(1'b0);
                end else if (tick) m_frames++;
            end
            4: if (rise) new_serve(1'b1);
            default: m_phase = 0;
        endcase
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, got, exp);
        end
    endtask

    // Full output comparison against the model.
    task automatic check_all(input string name);
        bit bad;
        n_tests++;
        bad = (int'(state) != m_phase) || (ball_reset != m_pulse) || (ball_run != (m_phase == 2)) ||
              (serve_dir != m_dir) || (int'(score1) != m_s1) || (int'(score2) != m_s2) ||
              (game_over != (m_phase == 4)) || ((m_phase == 4) && (winner != m_win));
        if (bad) begin
            n_fail++;
            $display("FAIL %s at %0t: got/required state %0d/%0d br %0d/%0d run %0d/%0d dir %0d/%0d s1 %0d/%0d s2 %0d/%0d over %0d/%0d win %0d/%0d",
                     name, $time, state, m_phase, ball_reset, m_pulse, ball_run, (m_phase == 2),
                     serve_dir, m_dir, score1, m_s1, score2, m_s2, game_over, (m_phase == 4), winner, m_win);
        end
    endtask

    task automatic cyc(input bit vs, input bit st, input bit ml, input bit mr);
        vsync = vs; start = st; miss_left = ml; miss_right = mr;
        @(posedge clk);
        model_step(vs, st, ml, mr);
        #1;
        check_all("cycle");
    endtask

    // One cycle with vsync toggling every cycle (one frame tick per two cycles).
    task automatic tcyc(input bit st, input bit ml, input bit mr);
        cyc(vs_phase[0], st, ml, mr);
        vs_phase++;
    endtask

    task automatic do_reset();
        reset = 1'b1; vsync = ~POL; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state");
        reset = 1'b0;
        vs_phase = 0;
    endtask

    task automatic wait_state(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(state) == target) return;
            tcyc(1'b0, 1'b0, 1'b0);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_state timeout: state %0d, required %0d", state, target);
    endtask

    task automatic wait_leave_point(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(state) != 3) return;
            tcyc(1'b0, 1'b0, 1'b0);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_point timeout: state %0d, required not 3", state);
    endtask

    // Play one rally ending in a miss by the left (p2 scores) or right (p1 scores) player.
    task automatic point(input bit left_miss);
        wait_state(2, 400);
        tcyc(1'b0, left_miss, !left_miss);
        wait_leave_point(400);
    endtask

    typedef struct {
        bit vs; bit st; bit ml; bit mr;
        int e_state; bit e_br; int e_s1; int e_s2;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{vs:1, st:0, ml:1, mr:0, e_state:0, e_br:0, e_s1:0, e_s2:0};
        tbl[1] = '{vs:1, st:0, ml:0, mr:1, e_state:0, e_br:0, e_s1:0, e_s2:0};
        tbl[2] = '{vs:0, st:1, ml:0, mr:0, e_state:1, e_br:1, e_s1:0, e_s2:0};
        tbl[3] = '{vs:1, st:1, ml:0, mr:0, e_state:1, e_br:0, e_s1:0, e_s2:0};
        tbl[4] = '{vs:0, st:0, ml:1, mr:1, e_state:1, e_br:0, e_s1:0, e_s2:0};
        tbl[5] = '{vs:1, st:1, ml:0, mr:0, e_state:1, e_br:0, e_s1:0, e_s2:0};
        tbl[6] = '{vs:0, st:0, ml:0, mr:1, e_state:1, e_br:0, e_s1:0, e_s2:0};
        tbl[7] = '{vs:1, st:0, ml:0, mr:0, e_state:1, e_br:0, e_s1:0, e_s2:0};

        do_reset();
        check("reset_serve_dir", serve_dir, 1);
        check("reset_state", state, 0);
        foreach (tbl[i]) begin
            cyc(tbl[i].vs, tbl[i].st, tbl[i].ml, tbl[i].mr);
            check($sformatf("vec%0d_state", i), state, tbl[i].e_state);
            check($sformatf("vec%0d_ball_reset", i), ball_reset, tbl[i].e_br);
            check($sformatf("vec%0d_score1", i), score1, tbl[i].e_s1);
            check($sformatf("vec%0d_score2", i), score2, tbl[i].e_s2);
        end

        // Serve, first point, point pause, double miss.
        do_reset();
        tcyc(1'b1, 1'b0, 1'b0);
        check("start_serve", state, 1);
        check("start_ball_reset", ball_reset, 1);
        wait_state(2, 400);
        check("play_ball_run", ball_run, 1);
        tcyc(1'b0, 1'b0, 1'b1);
        check("miss_right_state", state, 3);
        check("miss_right_score1", score1, 1);
        check("miss_right_dir", serve_dir, 1);
        check("miss_right_run_low", ball_run, 0);
        wait_state(1, 400);
        check("reserve_ball_reset", ball_reset, 1);
        wait_state(2, 400);
        tcyc(1'b0, 1'b1, 1'b1);
        check("double_miss_state", state, 1);
        check("double_miss_score1", score1, 1);
        check("double_miss_score2", score2, 0);
        check("double_miss_dir", serve_dir, 1);

        // Player 2 wins 11-5.
        for (int i = 0; i < 4; i++) point(1'b0);
        for (int i = 0; i < 10; i++) point(1'b1);
        check("p2_at_10_not_over", game_over, 0);
        point(1'b1);
        check("p2_win_state", state, 4);
        check("p2_win_game_over", game_over, 1);
        check("p2_win_winner", winner, 1);
        check("p2_win_score1", score1, 5);
        check("p2_win_score2", score2, 11);
        tcyc(1'b0, 1'b1, 1'b0);
        tcyc(1'b0, 1'b0, 1'b1);
        check("over_miss_score1", score1, 5);
        check("over_miss_score2", score2, 11);
        tcyc(1'b1, 1'b0, 1'b0);
        check("restart_state", state, 1);
        check("restart_score1", score1, 0);
        check("restart_score2", score2, 0);
        check("restart_ball_reset", ball_reset, 1);

        // Asynchronous reset during play at 3-4.
        for (int i = 0; i < 3; i++) point(1'b0);
        for (int i = 0; i < 4; i++) point(1'b1);
        wait_state(2, 400);
        check("pre_reset_score2", score2, 4);
        reset = 1'b1;
        #1;
        check("async_reset_state", state, 0);
        check("async_reset_score1", score1, 0);
        check("async_reset_score2", score2, 0);
        check("async_reset_run", ball_run, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        vs_phase = 0;
        tcyc(1'b0, 1'b1, 1'b1);
        check("idle_miss_state", state, 0);
        check("idle_miss_score", int'(score1) + int'(score2), 0);

        // Close game at 10-10 then 11-10.
        tcyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin point(1'b0); point(1'b1); end
        point(1'b0);
`ifdef PONG_WIN_BY_TWO_EN
        check("deuce_11_10_over", game_over, 0);
        point(1'b0);
        check("deuce_12_10_over", game_over, 1);
        check("deuce_12_10_winner", winner, 0);
        tcyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin point(1'b0); point(1'b1); end
        check("deuce_14_14_over", game_over, 0);
        point(1'b0);
        check("sat_15_14_score1", score1, 15);
        check("sat_15_14_over", game_over, 1);
        check("sat_15_14_winner", winner, 0);
`else
        check("first_to_11_over", game_over, 1);
        check("first_to_11_winner", winner, 0);
`endif

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 4999) == 0) do_reset();
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
